riscv_alu: RTL and testbench
============================

RISCV_ALU -- requirements
Module: riscv_alu

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width in bits; only 32 is required to be supported.
REQ-002 Port: clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_in  input  1  reset; asynchronous, active-high.
REQ-004 Port: valid_in  input  1  operands and function codes valid this cycle.
REQ-005 Port: alu_func_in  input  4  ALU operation select, encoded {funct7[5], funct3}.
REQ-006 Port: br_func_in  input  3  branch comparison select, encoded as RV32I branch funct3.
REQ-007 Port: a_in  input  XLEN  operand A (rs1 or PC).
REQ-008 Port: b_in  input  XLEN  operand B (rs2 or immediate).
REQ-009 Port: result_out  output  XLEN  registered ALU result.
REQ-010 Port: branch_taken_out  output  1  registered branch decision.
REQ-011 Port: valid_out  output  1  result_out and branch_taken_out hold a new result this cycle.

Function
REQ-012 alu_func_in encodings: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1010 COPY_B (result = b_in, used for LUI).
REQ-013 ADD and SUB wrap modulo 2^32; no overflow flag is produced.
REQ-014 Shift amount is b_in[4:0]; b_in[31:5] is ignored; SRA replicates a_in[31].
REQ-015 SLT compares signed and SLTU compares unsigned; result is 32'd1 if a_in < b_in, else 32'd0.
REQ-016 Any unlisted alu_func_in code yields result 32'd0.
REQ-017 br_func_in encodings: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010 and 011 are never taken.
REQ-018 Branch evaluation is independent of alu_func_in; both outputs are computed from the same a_in and b_in every valid cycle.
REQ-019 Latency is 1 cycle: when valid_in=1 at edge N, result_out, branch_taken_out and valid_out=1 are presented after edge N.
REQ-020 When valid_in=0 at an edge, valid_out goes to 0 and result_out and branch_taken_out hold their previous values.
REQ-021 Back-to-back valid inputs are accepted every cycle; there is no backpressure.

Reset
REQ-022 While rst_in=1, result_out=0, branch_taken_out=0 and valid_out=0, independent of clk_in.
REQ-023 If reset is asserted mid-stream, the in-flight result is discarded; the first valid_out after release corresponds to the first valid_in sampled after release.

Configuration
REQ-024 Macro RISCV_ALU_MUL_EN: when defined, code 1001 is MUL, and result = low 32 bits of a_in*b_in, with the same 1-cycle latency.
REQ-025 When RISCV_ALU_MUL_EN is undefined, code 1001 yields 0 per REQ-016 and no multiplier logic is synthesized.

Structure
REQ-026 ALU and branch function codes are localparams/enums in the shared package riscv_constants, which is also used by the decoder.
REQ-027 The barrel shifter (SLL/SRL/SRA) is one sub-module, riscv_alu_shifter, which is purely combinational.
REQ-028 All other logic is combinational next-state logic feeding a single output register stage in riscv_alu.

Verification
REQ-029 ADD 0xFFFFFFFF+0x00000001 -> result 0x00000000; SUB 0x00000000-0x00000001 -> 0xFFFFFFFF.
REQ-030 SRA a=0x80000000, b=0x00000024 (shamt 4) -> 0xF8000000; SRL on the same inputs -> 0x08000000; SLL a=1, b=31 -> 0x80000000.
REQ-031 SLT a=0xFFFFFFFF, b=1 -> 1; SLTU on the same inputs -> 0.
REQ-032 Branch a=0xFFFFFFFF, b=1: BLT taken, BLTU not taken, BGE not taken, BGEU taken, BNE taken, BEQ not taken; br_func 010 -> not taken.
REQ-033 valid_in pulsed for 3 consecutive cycles, then held low -> valid_out high for exactly 3 cycles, each one cycle later; outputs then hold.
REQ-034 rst_in asserted between clock edges while valid_out=1 -> all outputs 0 immediately; with RISCV_ALU_MUL_EN, 1001 with 0x10000 x 0x10000 -> 0x00000000 and 3 x 5 -> 15.

Source files
------------

// File: rtl/riscv_constants.sv
// Shared ALU and branch function encodings, used by the decoder and riscv_alu.
package riscv_constants;

  // ALU select is {funct7[5], funct3}
  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_MUL    = 4'b1001,
    ALU_COPY_B = 4'b1010,
    ALU_SRA    = 4'b1101
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_func_e;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } shift_op_e;

endpackage

// File: rtl/riscv_alu_shifter.sv
// Combinational barrel shifter for SLL / SRL / SRA.
module riscv_alu_shifter
  import riscv_constants::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         a_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  input  shift_op_e               op_i,
  output logic [XLEN-1:0]         result_o
);

  // NOTE: assign a default before the case so no path leaves result_o unassigned and infers a latch.
  always_comb begin
    result_o = '0;
    case (op_i)
      SH_SLL:  result_o = a_i << shamt_i;
      SH_SRL:  result_o = a_i >> shamt_i;
      SH_SRA:  result_o = $signed(a_i) >>> shamt_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_alu.sv
// RV32I ALU plus branch comparator with one output register stage.
// Optional MUL on code 1001 when RISCV_ALU_MUL_EN is defined.
module riscv_alu
  import riscv_constants::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            valid_in,
  input  logic [3:0]      alu_func_in,
  input  logic [2:0]      br_func_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] result_out,
  output logic            branch_taken_out,
  output logic            valid_out
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] result_d, result_q;
  logic            taken_d, taken_q;
  logic            valid_q;
  logic [XLEN-1:0] shift_res;
  shift_op_e       shift_op;
  logic            eq, lt_s, lt_u;

  assign eq   = (a_in == b_in);
  assign lt_s = ($signed(a_in) < $signed(b_in));
  assign lt_u = (a_in < b_in);

  always_comb begin
    shift_op = SH_SLL;
    if (alu_func_in == ALU_SRL)      shift_op = SH_SRL;
    else if (alu_func_in == ALU_SRA) shift_op = SH_SRA;
  end

  riscv_alu_shifter #(.XLEN(XLEN)) u_shifter (
    .a_i      (a_in),
    .shamt_i  (b_in[SHW-1:0]),
    .op_i     (shift_op),
    .result_o (shift_res)
  );

  always_comb begin
    result_d = '0;
    case (alu_func_in)
      ALU_ADD:    result_d = a_in + b_in;
      ALU_SUB:    result_d = a_in - b_in;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:    result_d = shift_res;
      ALU_SLT:    result_d = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:   result_d = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:    result_d = a_in ^ b_in;
      ALU_OR:     result_d = a_in | b_in;
      ALU_AND:    result_d = a_in & b_in;
      ALU_COPY_B: result_d = b_in;
`ifdef RISCV_ALU_MUL_EN
      ALU_MUL:    result_d = a_in * b_in;
`endif
      default:    result_d = '0;
    endcase
  end

  always_comb begin
    taken_d = 1'b0;
    case (br_func_in)
      BR_BEQ:  taken_d = eq;
      BR_BNE:  taken_d = ~eq;
      BR_BLT:  taken_d = lt_s;
      BR_BGE:  taken_d = ~lt_s;
      BR_BLTU: taken_d = lt_u;
      BR_BGEU: taken_d = ~lt_u;
      default: taken_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      result_q <= '0;
      taken_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_in;
      // Data registers only load on valid, so they hold during idle cycles.
      if (valid_in) begin
        result_q <= result_d;
        taken_q  <= taken_d;
      end
    end
  end

  assign result_out       = result_q;
  assign branch_taken_out = taken_q;
  assign valid_out        = valid_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed corner cases plus randomized ops against a reference model.
module tb_riscv_alu;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [3:0]  alu_func_in;
  logic [2:0]  br_func_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] result_out;
  logic        branch_taken_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  riscv_alu #(.XLEN(32)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .valid_in         (valid_in),
    .alu_func_in      (alu_func_in),
    .br_func_in       (br_func_in),
    .a_in             (a_in),
    .b_in             (b_in),
    .result_out       (result_out),
    .branch_taken_out (branch_taken_out),
    .valid_out        (valid_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic longint as_signed(input logic [31:0] v);
    return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] fill;
    s = b % 32;
    fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (f)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << s;
      4'b0101: return a >> s;
      4'b1101: return (a >> s) | fill;
      4'b0010: return (as_signed(a) < as_signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1010: return b;
`ifdef RISCV_ALU_MUL_EN
      4'b1001: return 32'((longint'(a) * longint'(b)) % 64'd4294967296);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return as_signed(a) < as_signed(b);
      3'b101: return as_signed(a) >= as_signed(b);
      3'b110: return longint'(a) < longint'(b);
      3'b111: return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  // Present one valid operation and return to a sampling point 1ns after the capturing edge.
  task automatic run_op(input logic [3:0] f, input logic [2:0] br, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_in);
    valid_in = 1'b1; alu_func_in = f; br_func_in = br; a_in = a; b_in = b;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    valid_in = 1'b1; alu_func_in = 4'b0000; br_func_in = 3'b001;
    a_in = 32'h1234_5678; b_in = 32'h1111_1111;
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (result_out !== 32'h0 || branch_taken_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%h taken=%b valid=%b, required 0/0/0", result_out, branch_taken_out, valid_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0; valid_in = 1'b0;
    @(posedge clk_in); #1;
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: valid=%b, required 0", valid_out);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  f [9]  = '{4'b0000, 4'b1000, 4'b1101, 4'b0101, 4'b0001, 4'b0010, 4'b0011, 4'b1010, 4'b1011};
    logic [31:0] a [9]  = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hDEAD_BEEF};
    logic [31:0] b [9]  = '{32'h1, 32'h1, 32'h24, 32'h24, 32'd31, 32'h1, 32'h1, 32'hABCD_E000, 32'h1234_5678};
    logic [31:0] ex [9] = '{32'h0, 32'hFFFF_FFFF, 32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h1, 32'h0, 32'hABCD_E000, 32'h0};
    for (int i = 0; i < 9; i++) begin
      run_op(f[i], 3'b000, a[i], b[i]);
      checks++;
      if (result_out !== ex[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL directed_alu[%0d] func=%b: result=%h valid=%b, required %h valid=1", i, f[i], result_out, valid_out, ex[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] br [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b000, 3'b010, 3'b011};
    logic       ex [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_op(4'b0000, br[i], 32'hFFFF_FFFF, 32'h1);
      checks++;
      if (branch_taken_out !== ex[i]) begin
        errors++;
        $display("FAIL directed_branch br=%b: taken=%b, required %b", br[i], branch_taken_out, ex[i]);
      end
    end
    run_op(4'b0000, 3'b000, 32'h5A5A_5A5A, 32'h5A5A_5A5A);
    checks++;
    if (branch_taken_out !== 1'b1) begin
      errors++;
      $display("FAIL beq_equal: taken=%b, required 1", branch_taken_out);
    end
  endtask

  task automatic test_random();
    logic [3:0]  f;
    logic [2:0]  br;
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      f  = 4'($urandom_range(0, 15));
      br = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 7) == 0) a = {a[31], 31'h0};
      run_op(f, br, a, b);
      checks++;
      if (result_out !== ref_alu(f, a, b) || branch_taken_out !== ref_br(br, a, b) || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] f=%b br=%b a=%h b=%h: result=%h taken=%b valid=%b, required %h %b 1",
                 i, f, br, a, b, result_out, branch_taken_out, valid_out, ref_alu(f, a, b), ref_br(br, a, b));
      end
    end
  endtask

  task automatic test_valid_pulse();
    logic [31:0] last_res;
    logic        last_tk;
    logic [31:0] a, b;
    logic [3:0]  f;
    logic [2:0]  br;
    logic        exp_v;
    last_res = 32'h0;
    last_tk  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      f = 4'($urandom_range(0, 7)); br = 3'($urandom_range(4, 7));
      a = $urandom(); b = $urandom();
      exp_v = (i < 3);
      @(negedge clk_in);
      valid_in = exp_v; alu_func_in = f; br_func_in = br; a_in = a; b_in = b;
      if (exp_v) begin
        last_res = ref_alu(f, a, b);
        last_tk  = ref_br(br, a, b);
      end
      @(posedge clk_in); #1;
      checks++;
      if (valid_out !== exp_v || result_out !== last_res || branch_taken_out !== last_tk) begin
        errors++;
        $display("FAIL valid_pulse[%0d]: valid=%b result=%h taken=%b, required %b %h %b",
                 i, valid_out, result_out, branch_taken_out, exp_v, last_res, last_tk);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_00FF, 32'hFFFF_0000};
    logic [31:0] b [4] = '{32'h1, 32'h8000_0000, 32'h0000_0F0F, 32'h0000_0010};
    logic [3:0]  f [4] = '{4'b0000, 4'b1000, 4'b0110, 4'b1101};
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], 3'b101, a[i], b[i]);
      checks++;
      if (valid_out !== 1'b1 || result_out !== ref_alu(f[i], a[i], b[i]) || branch_taken_out !== ref_br(3'b101, a[i], b[i])) begin
        errors++;
        $display("FAIL back_to_back[%0d]: valid=%b result=%h, required 1 %h", i, valid_out, result_out, ref_alu(f[i], a[i], b[i]));
      end
    end
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  task automatic test_reset_midstream();
    run_op(4'b0110, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F);
    checks++;
    if (valid_out !== 1'b1 || result_out !== 32'hF0F0_0F0F || branch_taken_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: valid=%b result=%h taken=%b, required 1 f0f00f0f 1", valid_out, result_out, branch_taken_out);
    end
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if (result_out !== 32'h0 || branch_taken_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: result=%h taken=%b valid=%b, required 0/0/0", result_out, branch_taken_out, valid_out);
    end
    @(posedge clk_in); #1;
    checks++;
    if (result_out !== 32'h0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: result=%h valid=%b, required 0/0", result_out, valid_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    valid_in = 1'b1; alu_func_in = 4'b0100; br_func_in = 3'b110;
    a_in = 32'h0000_FFFF; b_in = 32'hFFFF_FFFF;
    @(posedge clk_in); #1;
    checks++;
    if (valid_out !== 1'b1 || result_out !== 32'hFFFF_0000 || branch_taken_out !== 1'b1) begin
      errors++;
      $display("FAIL first_after_reset: valid=%b result=%h taken=%b, required 1 ffff0000 1", valid_out, result_out, branch_taken_out);
    end
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

`ifdef RISCV_ALU_MUL_EN
  task automatic test_mul();
    run_op(4'b1001, 3'b000, 32'h0001_0000, 32'h0001_0000);
    checks++;
    if (result_out !== 32'h0) begin
      errors++;
      $display("FAIL mul_wrap: result=%h, required 00000000", result_out);
    end
    run_op(4'b1001, 3'b000, 32'd3, 32'd5);
    checks++;
    if (result_out !== 32'd15) begin
      errors++;
      $display("FAIL mul_small: result=%h, required 0000000f", result_out);
    end
  endtask
`else
  task automatic test_mul_disabled();
    run_op(4'b1001, 3'b000, 32'd3, 32'd5);
    checks++;
    if (result_out !== 32'd0) begin
      errors++;
      $display("FAIL mul_disabled: result=%h, required 00000000", result_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_branch();
    test_valid_pulse();
    test_back_to_back();
    test_reset_midstream();
`ifdef RISCV_ALU_MUL_EN
    test_mul();
`else
    test_mul_disabled();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
